// File: rtl/mpeg_out_packer.sv
// mpeg_out_packer: drains the core's output byte FIFO (one-cycle read latency) through a
// small skid FIFO, packs bytes into 32-bit words and presents them on a valid/ready
// stream. A terminating word with word_last is emitted once every byte written into
// the core has come back out.
// Build option: define PACKER_BIG_ENDIAN_EN to place the first byte in word_out[31:24].
module mpeg_out_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       mpeg_out,
    input  logic             mpeg_empty,
    output logic             mpeg_rd,
    input  logic             stream_end,
    input  logic [CNT_W-1:0] in_cnt,
    output logic [31:0]      word_out,
    output logic [3:0]       word_keep,
    output logic             word_last,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CNT_W-1:0] out_cnt,
    output logic             done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StRun, StFlush, StLast, StDone} state_e;

    state_e           r_state;
    state_e           w_state_d;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_fifo_cnt;
    logic             r_rd_q;
    logic [CNT_W-1:0] r_out_cnt;

    logic [31:0]      r_asm_data;
    logic [2:0]       r_asm_cnt;

    logic [31:0]      r_word_out;
    logic [3:0]       r_word_keep;
    logic             r_word_last;
    logic             r_word_valid;

    logic             w_fifo_room;
    logic             w_push;
    logic             w_pop;
    logic             w_asm_full;
    logic             w_out_free;
    logic             w_load;
    logic             w_term_load;
    logic             w_end;
    logic [31:0]      w_asm_data_d;
    logic [2:0]       w_asm_cnt_d;
    logic [1:0]       w_lane;
    logic [3:0]       w_term_keep;

    // Skid FIFO occupancy plus the in-flight byte must stay below the depth.
    assign w_fifo_room = ({1'b0, r_fifo_cnt} + {{CW{1'b0}}, r_rd_q}) < (CW + 1)'(FIFO_DEPTH);
    assign mpeg_rd     = ~mpeg_empty & (r_state == StRun) & w_fifo_room;

    assign w_push      = r_rd_q;
    assign w_asm_full  = (r_asm_cnt == 3'd4);
    assign w_out_free  = ~r_word_valid | word_ready;
    assign w_load      = w_asm_full & w_out_free;
    assign w_term_load = (r_state == StFlush) & w_out_free;
    assign w_pop       = (r_fifo_cnt != '0) & (~w_asm_full | w_load);
    assign w_end       = stream_end & (r_out_cnt == in_cnt) & (r_fifo_cnt == '0) & ~r_rd_q;

`ifdef PACKER_BIG_ENDIAN_EN
    assign w_term_keep = ~(4'hF >> r_asm_cnt);
`else
    assign w_term_keep = (4'h1 << r_asm_cnt) - 4'h1;
`endif

    // In-flight tracking and captured-byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_q    <= 1'b0;
            r_out_cnt <= '0;
        end else begin
            r_rd_q <= mpeg_rd;
            if (r_rd_q) begin
                r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
        end
    end

    // Skid FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= mpeg_out;
        end
    end

    // Skid FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Assembly next state: drain on load, then drop a popped byte into its lane.
    always_comb begin
        w_asm_data_d = r_asm_data;
        w_asm_cnt_d  = r_asm_cnt;
        w_lane       = 2'd0;
        if (w_load || w_term_load) begin
            w_asm_data_d = '0;
            w_asm_cnt_d  = 3'd0;
        end
        if (w_pop) begin
`ifdef PACKER_BIG_ENDIAN_EN
            w_lane = 2'd3 - w_asm_cnt_d[1:0];
`else
            w_lane = w_asm_cnt_d[1:0];
`endif
            w_asm_data_d[{w_lane, 3'b000} +: 8] = r_mem[r_rptr];
            w_asm_cnt_d = w_asm_cnt_d + 3'd1;
        end
    end

    // Assembly register; unused lanes stay zero so the terminator is already padded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm_data <= '0;
            r_asm_cnt  <= 3'd0;
        end else begin
            r_asm_data <= w_asm_data_d;
            r_asm_cnt  <= w_asm_cnt_d;
        end
    end

    // Output register: full word, terminator, or retire on transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_out   <= '0;
            r_word_keep  <= 4'h0;
            r_word_last  <= 1'b0;
            r_word_valid <= 1'b0;
        end else if (w_load) begin
            r_word_out   <= r_asm_data;
            r_word_keep  <= 4'hF;
            r_word_last  <= 1'b0;
            r_word_valid <= 1'b1;
        end else if (w_term_load) begin
            r_word_out   <= r_asm_data;
            r_word_keep  <= w_term_keep;
            r_word_last  <= 1'b1;
            r_word_valid <= 1'b1;
        end else if (r_word_valid && word_ready) begin
            r_word_valid <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next state: flush once every byte is home and nothing full is pending.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StRun:   if (w_end && !w_asm_full) w_state_d = StFlush;
            StFlush: if (w_out_free) w_state_d = StLast;
            StLast:  if (r_word_valid && word_ready) w_state_d = StDone;
            StDone:  w_state_d = StDone;
            default: w_state_d = StRun;
        endcase
    end

    assign word_out   = r_word_out;
    assign word_keep  = r_word_keep;
    assign word_last  = r_word_last;
    assign word_valid = r_word_valid;
    assign out_cnt    = r_out_cnt;
    assign done       = (r_state == StDone);

endmodule
